// File: rtl/between_pkg.sv
// Shared definitions for the "between" parallel link: data width and link FSM encoding.
// The out_to_between sender reuses DATA_W from here.
package between_pkg;

   localparam int DATA_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } link_state_t;

endpackage

// File: rtl/between_to_in_if.sv
// Receive-side bundle: parallel link (t0..t7, tsent/trecieve) plus the consumer valid/ready port.
// master = sender/consumer environment, slave = the receiver block.
interface between_to_in_if #(
   parameter int ADDR_W = 2
);
   import between_pkg::*;

   logic t0, t1, t2, t3, t4, t5, t6, t7;
   logic tsent;
   logic trecieve;
   logic [DATA_W-1:0] out_data;
   logic out_valid;
   logic out_ready;
   logic [ADDR_W:0] level;
   logic overrun;

   modport master (
      output t0, t1, t2, t3, t4, t5, t6, t7, tsent, out_ready,
      input  trecieve, out_data, out_valid, level, overrun
   );

   modport slave (
      input  t0, t1, t2, t3, t4, t5, t6, t7, tsent, out_ready,
      output trecieve, out_data, out_valid, level, overrun
   );

endinterface

// File: rtl/between_rx_fifo.sv
// First-word fall-through FIFO (DEPTH x DATA_W) with an occupancy output.
// Pointers carry one extra bit so level = wr_ptr - rd_ptr distinguishes full from empty.
module between_rx_fifo
   import between_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = (level == (ADDR_W+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head byte is masked while empty so out_data reads 0 after reset.
   assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/between_to_in.sv
// Receive side of the "between" link: captures t0..t7 on tsent, acknowledges on trecieve,
// and buffers bytes for a valid/ready consumer. Back-pressure = withholding trecieve when full.
module between_to_in
   import between_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input logic             clk,
   input logic             rst_n,
   between_to_in_if.slave  bus
);

   link_state_t       state;
   logic              after_ack;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] link_byte;

   // t0 is the MSB of the byte on the wire.
   assign link_byte = {bus.t0, bus.t1, bus.t2, bus.t3, bus.t4, bus.t5, bus.t6, bus.t7};

   // Full is taken from the registered level, so a same-cycle pop cannot make room for a push.
   assign push = (state == IDLE) && bus.tsent && !full;
   assign pop  = bus.out_ready && !empty;

   assign bus.out_valid = !empty;

   // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bus.trecieve <= 1'b0;
         after_ack    <= 1'b0;
         bus.overrun  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               after_ack <= 1'b0;
               // tsent still high in the first IDLE cycle after ACK: sender skipped the gap.
               if (after_ack && bus.tsent) bus.overrun <= 1'b1;
               if (push) begin
                  bus.trecieve <= 1'b1;
                  state        <= ACK;
               end
            end
            ACK: begin
               if (!bus.tsent) begin
                  bus.trecieve <= 1'b0;
                  after_ack    <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               bus.trecieve <= 1'b0;
               after_ack    <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

   between_rx_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (link_byte),
      .pop     (pop),
      .rd_data (bus.out_data),
      .empty   (empty),
      .full    (full),
      .level   (bus.level)
   );

endmodule

// File: tb/tb_between_to_in.sv
// Directed + randomized bench for between_to_in; a byte queue is the reference for
// ordering, occupancy and back-pressure, checked with immediate assertions.
`timescale 1ns/1ps
module tb_between_to_in;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   bit   rand_ready;
   logic [7:0] q[$];
   logic exp_overrun;

   between_to_in_if #(.ADDR_W(ADDR_W)) bus();

   between_to_in #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic drive_byte(input logic [7:0] b);
      {bus.t0, bus.t1, bus.t2, bus.t3, bus.t4, bus.t5, bus.t6, bus.t7} = b;
   endtask

   // Compare against the model at the current negedge, then advance one clock.
   task automatic tick();
      if (rst_n) begin
         check("level", 32'(bus.level), 32'(q.size()));
         check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         if (bus.out_valid && bus.out_ready && q.size() != 0) begin
            check("out_data", 32'(bus.out_data), 32'(q[0]));
            void'(q.pop_front());
         end
      end
      @(negedge clk);
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
   endtask

   // One sender handshake; gap=1 leaves an extra idle cycle before the next byte.
   task automatic send(input logic [7:0] b, input bit gap);
      int  lat;
      bit  was_full;
      was_full = (q.size() == DEPTH);
      drive_byte(b);
      bus.tsent = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.trecieve && lat < 40);
      check("ack_seen", 32'(bus.trecieve), 32'd1);
      if (!was_full) check("ack_latency", 32'(lat), 32'd1);
      if (bus.trecieve) q.push_back(b);
      tick();
      check("ack_held", 32'(bus.trecieve), 32'd1);
      bus.tsent = 1'b0;
      tick();
      check("ack_drop", 32'(bus.trecieve), 32'd0);
      if (gap) tick();
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      bus.out_ready = 1'b0;
      tick();
      check("drained", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rand_ready = 1'b0;
      exp_overrun = 1'b0;
      rst_n = 1'b0;
      bus.tsent = 1'b0;
      bus.out_ready = 1'b0;
      drive_byte(8'h00);
      #1;
      check("rst_trecieve", 32'(bus.trecieve), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_level", 32'(bus.level), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single byte, then pop.
      send(8'hA5, 1'b1);
      check("single_data", 32'(bus.out_data), 32'hA5);
      check("single_level", 32'(bus.level), 32'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tick();
      check("single_empty", 32'(bus.level), 32'd0);

      // Fill to DEPTH; fifth byte stalls until a pop, then lands one edge later.
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
      drive_byte(8'h05);
      bus.tsent = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_stall", 32'(bus.trecieve), 32'd0);
      end
      check("full_level", 32'(bus.level), 32'd4);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("pop_no_push", 32'(bus.trecieve), 32'd0);
      check("pop_level", 32'(bus.level), 32'd3);
      tick();
      check("late_ack", 32'(bus.trecieve), 32'd1);
      q.push_back(8'h05);
      check("late_level", 32'(bus.level), 32'd4);
      tick();
      bus.tsent = 1'b0;
      tick();
      check("late_drop", 32'(bus.trecieve), 32'd0);
      tick();
      drain();

      // Long tsent: exactly one write.
      drive_byte(8'h3C);
      bus.tsent = 1'b1;
      tick();
      check("long_ack", 32'(bus.trecieve), 32'd1);
      q.push_back(8'h3C);
      for (int i = 0; i < 9; i++) begin
         tick();
         check("long_hold", 32'(bus.trecieve), 32'd1);
      end
      bus.tsent = 1'b0;
      tick();
      check("long_drop", 32'(bus.trecieve), 32'd0);
      check("long_level", 32'(bus.level), 32'd1);
      tick();
      drain();

      // Stream with consumer always ready.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(8'($urandom), 1'b1);
         check("stream_level", 32'(bus.level <= 1), 32'd1);
      end
      bus.out_ready = 1'b0;
      drain();
      check("stream_overrun", 32'(bus.overrun), 32'(exp_overrun));

      // Randomized consumer back-pressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 24; i++) send(8'($urandom), 1'b1);
      rand_ready = 1'b0;
      drain();

      // Reset while acknowledging with two bytes buffered.
      send(8'h5A, 1'b1);
      drive_byte(8'hC3);
      bus.tsent = 1'b1;
      tick();
      check("pre_rst_ack", 32'(bus.trecieve), 32'd1);
      q.push_back(8'hC3);
      check("pre_rst_level", 32'(bus.level), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_trecieve", 32'(bus.trecieve), 32'd0);
      check("mid_rst_level", 32'(bus.level), 32'd0);
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_data", 32'(bus.out_data), 32'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("recapture_ack", 32'(bus.trecieve), 32'd1);
      q.push_back(8'hC3);
      check("recapture_level", 32'(bus.level), 32'd1);
      tick();
      bus.tsent = 1'b0;
      tick();
      tick();
      drain();

      // Overrun: second byte raised immediately after trecieve falls.
      send(8'h11, 1'b0);
      send(8'h22, 1'b1);
      exp_overrun = 1'b1;
      check("overrun_set", 32'(bus.overrun), 32'(exp_overrun));
      check("overrun_stored", 32'(bus.level), 32'd2);
      drain();
      repeat (3) tick();
      check("overrun_sticky", 32'(bus.overrun), 32'(exp_overrun));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
